// File: rtl/led_trail_pkg.sv
// Shared constants for the LED trail PWM block: default parameters and the gamma curve.
// The gamma curve is only used when LED_TRAIL_GAMMA_EN is defined.
package led_trail_pkg;

  localparam int NUM_LEDS       = 8;
  localparam int PWM_BITS_DEF   = 4;
  localparam int DECAY_DIV_DEF  = 16;
  localparam int DECAY_STEP_DEF = 2;

  // Index 0 is the rightmost element: 0,0,0,1,1,2,3,4,5,6,7,9,10,12,13,15
  localparam logic [15:0][3:0] GAMMA_LUT = {
    4'd15, 4'd13, 4'd12, 4'd10, 4'd9, 4'd7, 4'd6, 4'd5,
    4'd4,  4'd3,  4'd2,  4'd1,  4'd1, 4'd0, 4'd0, 4'd0
  };

  function automatic logic [3:0] gamma4(input logic [3:0] lvl);
    return GAMMA_LUT[lvl];
  endfunction

endpackage

// File: rtl/led_trail_cell.sv
// One LED channel: brightness register with load/decay, PWM compare and output flop.
// With LED_TRAIL_GAMMA_EN defined the compare uses the gamma-corrected level.
module led_trail_cell
  import led_trail_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                load,
  input  logic                decay_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_pwm
);

  localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level_reg;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] eff_level;
  logic                led_pwm_reg;

  // A fresh hit always wins over a coincident decay tick.
  always_comb begin
    level_next = level_reg;
    if (load) begin
      level_next = MAX_LEVEL;
    end else if (decay_tick) begin
      level_next = (level_reg > STEP) ? level_reg - STEP : '0;
    end
  end

`ifdef LED_TRAIL_GAMMA_EN
  assign eff_level = PWM_BITS'(gamma4(4'(level_reg)));
`else
  assign eff_level = level_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg   <= '0;
      led_pwm_reg <= 1'b0;
    end else if (enable) begin
      level_reg   <= level_next;
      led_pwm_reg <= (eff_level > pwm_cnt);
    end else begin
      led_pwm_reg <= 1'b0;
    end
  end

  assign led_pwm = led_pwm_reg;

endmodule

// File: rtl/led_trail_pwm.sv
// Fading-trail PWM driver for an 8-LED chaser; shared PWM/decay timebase plus 8 cells.
// Optional gamma correction is enabled by defining LED_TRAIL_GAMMA_EN (requires PWM_BITS = 4).
module led_trail_pwm
  import led_trail_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_DIV  = DECAY_DIV_DEF,
  parameter int DECAY_STEP = DECAY_STEP_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] pattern_in,
  output logic [7:0] led_pwm,
  output logic       pwm_sync
);

  localparam int DIV_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DECAY_DIV - 1);

`ifdef LED_TRAIL_GAMMA_EN
  generate
    if (PWM_BITS != 4) begin : g_gamma_width_check
      $error("led_trail_pwm: gamma table needs PWM_BITS == 4");
    end
  endgenerate
`endif

  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic [DIV_W-1:0]    decay_cnt_reg;
  logic                pwm_sync_reg;
  logic                decay_tick;

  assign decay_tick = enable && (decay_cnt_reg == DIV_LAST);

  // Period is MAX cycles (0..MAX-1) so level MAX stays on for the whole period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_reg   <= '0;
      decay_cnt_reg <= '0;
      pwm_sync_reg  <= 1'b0;
    end else if (enable) begin
      pwm_cnt_reg   <= (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + 1'b1;
      decay_cnt_reg <= decay_tick ? '0 : decay_cnt_reg + 1'b1;
      pwm_sync_reg  <= (pwm_cnt_reg == '0);
    end else begin
      pwm_sync_reg  <= 1'b0;
    end
  end

  assign pwm_sync = pwm_sync_reg;

  generate
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_cell
      led_trail_cell #(
        .PWM_BITS  (PWM_BITS),
        .DECAY_STEP(DECAY_STEP)
      ) u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (enable && pattern_in[gi]),
        .decay_tick(decay_tick),
        .pwm_cnt   (pwm_cnt_reg),
        .led_pwm   (led_pwm[gi])
      );
    end
  endgenerate

endmodule
